// File: rtl/pipeline_spi_pkg.sv
// Shared definitions for the pipeline SPI control link (master and slave).
// Opcodes, per-opcode payload sizes, SPI mode and the master FSM state type.
package pipeline_spi_pkg;

    localparam logic [7:0] OVERLAY_MODE    = 8'h01;
    localparam logic [7:0] FG_SCALE        = 8'h03;
    localparam logic [7:0] FG_OFFSET_X     = 8'h04;
    localparam logic [7:0] FG_OFFSET_Y     = 8'h05;
    localparam logic [7:0] FG_CLIP_LEFT    = 8'h06;
    localparam logic [7:0] FG_CLIP_RIGHT   = 8'h07;
    localparam logic [7:0] FG_CLIP_TOP     = 8'h08;
    localparam logic [7:0] FG_CLIP_BOTTOM  = 8'h09;

    // CPOL=0, CPHA=0
    localparam int unsigned SPI_MODE = 0;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StShiftHi,
        StShiftLo,
        StGap
    } spi_state_e;

    function automatic logic [2:0] payload_len(input logic [7:0] opcode);
        logic [2:0] len;
        len = 3'd0;
        case (opcode)
            OVERLAY_MODE:                       len = 3'd1;
            FG_SCALE, FG_OFFSET_X, FG_OFFSET_Y: len = 3'd2;
            FG_CLIP_LEFT, FG_CLIP_RIGHT,
            FG_CLIP_TOP, FG_CLIP_BOTTOM:        len = 3'd2;
            default:                            len = 3'd0;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/pipeline_spi_master_phase_timer.sv
// Phase timer: CLK_DIV down-counter with load; tc_o marks the last cycle of a phase.
module spi_phase_timer #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    output logic tc_o
);

    localparam int unsigned W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [W-1:0] LoadVal = W'(CLK_DIV - 1);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= LoadVal;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/pipeline_spi_master.sv
// SPI mode 0 initiator: one opcode plus 0..MAX_PAYLOAD payload bytes per ss-low frame,
// MISO captured into rsp_data and reported with a one-cycle rsp_valid at frame end.
module pipeline_spi_master
    import pipeline_spi_pkg::*;
#(
    parameter int unsigned CLK_DIV     = 2,
    parameter int unsigned MAX_PAYLOAD = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_opcode,
    input  logic [2:0]  cmd_len,
    input  logic [31:0] cmd_data,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        busy,
    output logic        hw_spi_clk,
    output logic        hw_spi_ss,
    output logic        hw_spi_mosi,
    input  logic        hw_spi_miso
);

    spi_state_e  state_q;
    logic        cmd_ready_q, rsp_valid_q, busy_q, sclk_q, ss_q, mosi_q;
    logic [31:0] rsp_data_q, rx_q;
    logic [38:0] tx_q;
    logic [5:0]  bit_cnt_q;

    logic [2:0]  len_clamp;
    logic [39:0] frame_bits;
    logic        accept, tc, timer_load;

    assign len_clamp = (cmd_len > 3'(MAX_PAYLOAD)) ? 3'(MAX_PAYLOAD) : cmd_len;

    // Left-align the frame so bit 39 is always the first bit on the wire.
    always_comb begin
        frame_bits = {cmd_opcode, 32'h0};
        case (len_clamp)
            3'd0:    frame_bits = {cmd_opcode, 32'h0};
            3'd1:    frame_bits = {cmd_opcode, cmd_data[7:0], 24'h0};
            3'd2:    frame_bits = {cmd_opcode, cmd_data[15:0], 16'h0};
            3'd3:    frame_bits = {cmd_opcode, cmd_data[23:0], 8'h0};
            default: frame_bits = {cmd_opcode, cmd_data};
        endcase
    end

    assign accept     = (state_q == StIdle) && cmd_valid && cmd_ready_q;
    assign timer_load = accept || ((state_q != StIdle) && tc);

    spi_phase_timer #(
        .CLK_DIV(CLK_DIV)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load_i(timer_load),
        .tc_o  (tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            busy_q      <= 1'b0;
            sclk_q      <= 1'b0;
            ss_q        <= 1'b1;
            mosi_q      <= 1'b0;
            tx_q        <= '0;
            rx_q        <= '0;
            bit_cnt_q   <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    cmd_ready_q <= 1'b1;
                    if (accept) begin
                        state_q     <= StSetup;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        ss_q        <= 1'b0;
                        sclk_q      <= 1'b0;
                        tx_q        <= frame_bits[38:0];
                        mosi_q      <= frame_bits[39];
                        bit_cnt_q   <= {len_clamp, 3'b111};
                        rx_q        <= '0;
                    end
                end
                StSetup: begin
                    if (tc) begin
                        state_q <= StShiftHi;
                        sclk_q  <= 1'b1;
                        rx_q    <= {rx_q[30:0], hw_spi_miso};
                    end
                end
                StShiftHi: begin
                    if (tc) begin
                        state_q <= StShiftLo;
                        sclk_q  <= 1'b0;
                        // The last bit stays on MOSI through the final low phase.
                        if (bit_cnt_q != '0) begin
                            tx_q   <= {tx_q[37:0], 1'b0};
                            mosi_q <= tx_q[38];
                        end
                    end
                end
                StShiftLo: begin
                    if (tc) begin
                        if (bit_cnt_q == '0) begin
                            state_q     <= StGap;
                            ss_q        <= 1'b1;
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= rx_q;
                        end else begin
                            state_q   <= StShiftHi;
                            bit_cnt_q <= bit_cnt_q - 6'd1;
                            sclk_q    <= 1'b1;
                            rx_q      <= {rx_q[30:0], hw_spi_miso};
                        end
                    end
                end
                StGap: begin
                    if (tc) begin
                        state_q     <= StIdle;
                        busy_q      <= 1'b0;
                        cmd_ready_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign busy        = busy_q;
    assign hw_spi_clk  = sclk_q;
    assign hw_spi_ss   = ss_q;
    assign hw_spi_mosi = mosi_q;

endmodule

// File: tb/tb_pipeline_spi_master.sv
// Scoreboard bench: instance 0 runs CLK_DIV=2, instance 1 runs CLK_DIV=1, MISO looped to MOSI.
module tb_pipeline_spi_master;

    typedef struct {
        int          ss_cyc;
        int          edges;
        logic [39:0] mosi;
        logic [31:0] rsp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_r [2];
    logic [7:0]  op_r    [2];
    logic [2:0]  len_r   [2];
    logic [31:0] data_r  [2];
    logic        ready_w [2];
    logic        rspv_w  [2];
    logic [31:0] rspd_w  [2];
    logic        busy_w  [2];
    logic        sclk_w  [2];
    logic        ss_w    [2];
    logic        mosi_w  [2];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    exp_t        exp0[$];
    exp_t        exp1[$];
    logic        in_fr     [2] = '{0, 0};
    logic        prev_sclk [2] = '{0, 0};
    int          ss_cnt    [2] = '{0, 0};
    int          edges     [2] = '{0, 0};
    int          hi_cnt    [2] = '{0, 0};
    int          last_hi   [2] = '{0, 0};
    int          rsp_cyc   [2] = '{0, 0};
    logic [39:0] acc       [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pipeline_spi_master #(.CLK_DIV(2), .MAX_PAYLOAD(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(valid_r[0]), .cmd_ready(ready_w[0]), .cmd_opcode(op_r[0]),
        .cmd_len(len_r[0]), .cmd_data(data_r[0]), .rsp_valid(rspv_w[0]),
        .rsp_data(rspd_w[0]), .busy(busy_w[0]), .hw_spi_clk(sclk_w[0]),
        .hw_spi_ss(ss_w[0]), .hw_spi_mosi(mosi_w[0]), .hw_spi_miso(mosi_w[0])
    );

    pipeline_spi_master #(.CLK_DIV(1), .MAX_PAYLOAD(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(valid_r[1]), .cmd_ready(ready_w[1]), .cmd_opcode(op_r[1]),
        .cmd_len(len_r[1]), .cmd_data(data_r[1]), .rsp_valid(rspv_w[1]),
        .rsp_data(rspd_w[1]), .busy(busy_w[1]), .hw_spi_clk(sclk_w[1]),
        .hw_spi_ss(ss_w[1]), .hw_spi_mosi(mosi_w[1]), .hw_spi_miso(mosi_w[1])
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int qsize(input int d);
        return (d == 0) ? exp0.size() : exp1.size();
    endfunction

    task automatic mon_step(input int d);
        logic ended;
        exp_t e;
        ended = 1'b0;
        if (!rst_n) begin
            in_fr[d]     = 1'b0;
            prev_sclk[d] = 1'b0;
            check($sformatf("rst_ss%0d", d), 64'(ss_w[d]), 64'd1);
            check($sformatf("rst_sclk%0d", d), 64'(sclk_w[d]), 64'd0);
            return;
        end
        if (!ss_w[d]) begin
            if (!in_fr[d]) begin
                in_fr[d]   = 1'b1;
                ss_cnt[d]  = 0;
                edges[d]   = 0;
                acc[d]     = '0;
                last_hi[d] = hi_cnt[d];
            end
            hi_cnt[d] = 0;
            ss_cnt[d]++;
            if (sclk_w[d] && !prev_sclk[d]) begin
                edges[d]++;
                acc[d] = {acc[d][38:0], mosi_w[d]};
            end
            check($sformatf("ready_in_frame%0d", d), 64'(ready_w[d]), 64'd0);
        end else begin
            hi_cnt[d]++;
            check($sformatf("sclk_ss_high%0d", d), 64'(sclk_w[d]), 64'd0);
            if (in_fr[d]) begin
                ended    = 1'b1;
                in_fr[d] = 1'b0;
                check($sformatf("rsp_at_ss_rise%0d", d), 64'(rspv_w[d]), 64'd1);
            end
        end
        if (rspv_w[d]) begin
            rsp_cyc[d] = cyc;
            check($sformatf("rsp_aligned%0d", d), 64'(ended), 64'd1);
            if (qsize(d) == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp%0d: got rsp_valid, required none", d);
            end else begin
                if (d == 0) e = exp0.pop_front();
                else e = exp1.pop_front();
                check($sformatf("rsp_data%0d", d), 64'(rspd_w[d]), 64'(e.rsp));
                check($sformatf("ss_low_cycles%0d", d), 64'(ss_cnt[d]), 64'(e.ss_cyc));
                check($sformatf("sclk_edges%0d", d), 64'(edges[d]), 64'(e.edges));
                check($sformatf("mosi_stream%0d", d), 64'(acc[d]), 64'(e.mosi));
            end
        end
        prev_sclk[d] = sclk_w[d];
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) mon_step(d);
    end

    task automatic push(input int d, input int ssc, input int ed, input logic [39:0] m,
                        input logic [31:0] r);
        exp_t e;
        e.ss_cyc = ssc;
        e.edges  = ed;
        e.mosi   = m;
        e.rsp    = r;
        if (d == 0) exp0.push_back(e);
        else exp1.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge after the accepting clock edge.
    task automatic send(input int d, input logic [7:0] op, input logic [2:0] len,
                        input logic [31:0] data, input bit keep, output int acc_cyc);
        int n;
        valid_r[d] = 1'b1;
        op_r[d]    = op;
        len_r[d]   = len;
        data_r[d]  = data;
        n = 0;
        while (!ready_w[d] && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!ready_w[d]) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout%0d: cmd_ready stayed 0, required 1", d);
        end
        acc_cyc = cyc;
        @(negedge clk);
        if (!keep) valid_r[d] = 1'b0;
    endtask

    task automatic wait_done(input int d);
        int n;
        n = 0;
        while ((busy_w[d] || qsize(d) != 0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (busy_w[d] || qsize(d) != 0) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout%0d: busy %0d pending %0d, required 0 0",
                     d, busy_w[d], qsize(d));
        end
        @(negedge clk);
    endtask

    initial begin
        int a1, a2, n, ox;
        for (int d = 0; d < 2; d++) begin
            valid_r[d] = 1'b0;
            op_r[d]    = '0;
            len_r[d]   = '0;
            data_r[d]  = '0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("reset_mosi", 64'(mosi_w[d]), 64'd0);
            check("reset_ready", 64'(ready_w[d]), 64'd0);
            check("reset_rspv", 64'(rspv_w[d]), 64'd0);
            check("reset_rspd", 64'(rspd_w[d]), 64'd0);
            check("reset_busy", 64'(busy_w[d]), 64'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst0", 64'(ready_w[0]), 64'd1);
        check("ready_after_rst1", 64'(ready_w[1]), 64'd1);

        // Opcode only.
        push(0, 34, 8, 40'h01, 32'h01);
        send(0, 8'h01, 3'd0, 32'h0, 1'b0, a1);
        wait_done(0);

        // FG_OFFSET_X = -10.
        push(0, 98, 24, 40'h04FFF6, 32'h0004FFF6);
        send(0, 8'h04, 3'd2, 32'h0000FFF6, 1'b0, a1);
        wait_done(0);
        ox = int'($signed(rspd_w[0][15:0]));
        check("slave_offset_x", 64'(ox), 64'(-10));
        check("slave_opcode", 64'(rspd_w[0][23:16]), 64'h04);

        // Length clamp.
        push(0, 162, 40, 40'h05DEADBEEF, 32'hDEADBEEF);
        send(0, 8'h05, 3'd7, 32'hDEADBEEF, 1'b0, a1);
        wait_done(0);

        // Back-to-back with cmd_valid held.
        push(0, 66, 16, 40'h0311, 32'h0311);
        push(0, 66, 16, 40'h0622, 32'h0622);
        send(0, 8'h03, 3'd1, 32'hFFFF_FF11, 1'b1, a1);
        send(0, 8'h06, 3'd1, 32'h0000_0022, 1'b0, a2);
        check("b2b_accept_delay", 64'(a2 - rsp_cyc[0]), 64'd2);
        @(negedge clk);
        check("b2b_ss_high", 64'(last_hi[0]), 64'd3);
        wait_done(0);

        // Reset in the middle of a frame.
        send(0, 8'h07, 3'd2, 32'h1234, 1'b0, a1);
        n = 0;
        while (edges[0] < 5 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("abort_reached_edge5", 64'(edges[0] >= 5), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check("abort_ss", 64'(ss_w[0]), 64'd1);
        check("abort_sclk", 64'(sclk_w[0]), 64'd0);
        check("abort_busy", 64'(busy_w[0]), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_ready", 64'(ready_w[0]), 64'd1);
        check("abort_rspd", 64'(rspd_w[0]), 64'd0);
        push(0, 66, 16, 40'h025A, 32'h025A);
        send(0, 8'h02, 3'd1, 32'h5A, 1'b0, a1);
        wait_done(0);

        // CLK_DIV=1 instance.
        push(1, 33, 16, 40'hA53C, 32'hA53C);
        send(1, 8'hA5, 3'd1, 32'h3C, 1'b0, a1);
        wait_done(1);

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
